// File: rtl/in_mapper.sv
// AER event to SpiNNaker multicast packet mapper with a small decoupling FIFO.
// Optional IN_MAPPER_TSTAMP_EN adds a 32-bit timestamp payload to every packet.
module in_mapper #(
  parameter int AER_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          key_prefix,
  input  logic [31:0]          key_mask,
  input  logic [AER_WIDTH-1:0] iaer_data,
  input  logic                 iaer_vld,
  output logic                 iaer_rdy,
  output logic [71:0]          ipkt_data,
  output logic                 ipkt_vld,
  input  logic                 ipkt_rdy,
  output logic [31:0]          evt_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [71:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             active;
  logic             full;
  logic             empty;
  logic             wr_en;
  logic             rd_en;

  logic [31:0]      key;
  logic [31:0]      payload;
  logic [6:0]       hdr_hi;
  logic             parity;
  logic [71:0]      new_pkt;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Input side is held off until one clock after reset release, and never
  // looks at ipkt_rdy, so the two interfaces share no combinational path.
  assign iaer_rdy = active & ~full;
  assign ipkt_vld = ~empty;
  assign wr_en    = iaer_vld & iaer_rdy;
  assign rd_en    = ipkt_vld & ipkt_rdy;

`ifdef IN_MAPPER_TSTAMP_EN
  logic [31:0] tstamp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tstamp <= '0;
    else     tstamp <= tstamp + 32'd1;
  end
`endif

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    key     = (32'(iaer_data) & key_mask) | key_prefix;
    payload = '0;
    hdr_hi  = '0;
`ifdef IN_MAPPER_TSTAMP_EN
    payload   = tstamp;
    hdr_hi[0] = 1'b1;
`endif
    // Odd parity over the whole packet: bit0 makes the 72-bit XOR equal 1.
    parity  = ~^{payload, key, hdr_hi};
    new_pkt = {payload, key, hdr_hi, parity};
  end

  // NOTE: storage is reset here so ipkt_data reads 0 during reset; fine for a few entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= new_pkt;
    end
  end

  assign ipkt_data = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      active    <= 1'b0;
      evt_count <= '0;
    end else begin
      active <= 1'b1;
      if (wr_en)
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_en) begin
        rd_ptr    <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        evt_count <= evt_count + 32'd1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_in_mapper.sv
// Directed, table-driven bench for in_mapper: key/header/parity vectors plus
// back-pressure, streaming, mid-operation reset and optional timestamp sequences.
module tb_in_mapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] key_prefix;
  logic [31:0] key_mask;
  logic [31:0] iaer_data;
  logic        iaer_vld;
  logic        iaer_rdy;
  logic [71:0] ipkt_data;
  logic        ipkt_vld;
  logic        ipkt_rdy;
  logic [31:0] evt_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_count;

  in_mapper #(.AER_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_prefix (key_prefix),
    .key_mask   (key_mask),
    .iaer_data  (iaer_data),
    .iaer_vld   (iaer_vld),
    .iaer_rdy   (iaer_rdy),
    .ipkt_data  (ipkt_data),
    .ipkt_vld   (ipkt_vld),
    .ipkt_rdy   (ipkt_rdy),
    .evt_count  (evt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] prefix;
    logic [31:0] aer;
    logic [31:0] key;
    logic [7:0]  hdr;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    exp_count = '0;
  endtask

  initial begin
    rst        = 1'b1;
    key_prefix = '0;
    key_mask   = 32'hFFFF_FFFF;
    iaer_data  = '0;
    iaer_vld   = 1'b0;
    ipkt_rdy   = 1'b0;
    exp_count  = '0;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001, 8'h00};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0003, 32'h0000_0003, 8'h01};
    vecs[2] = '{32'h0000_FFFF, 32'hAB00_0000, 32'h1234_5678, 32'hAB00_5678, 8'h00};
    vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_0000, 8'h01};
    vecs[4] = '{32'hF0F0_F0F0, 32'h0000_0001, 32'h1234_5678, 32'h1030_5071, 8'h00};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h01};

    // Reset state while rst is held
    #2;
    tick();
    check("rst_vld", 72'(ipkt_vld), 72'd0);
    check("rst_data", ipkt_data, 72'd0);
    check("rst_rdy", 72'(iaer_rdy), 72'd0);
    check("rst_count", 72'(evt_count), 72'd0);
    rst = 1'b0;
    tick();
    check("rdy_after_rst", 72'(iaer_rdy), 72'd1);

    // Table: one event in, one packet out, each checked field by field
    for (int v = 0; v < 6; v++) begin
      key_mask   = vecs[v].mask;
      key_prefix = vecs[v].prefix;
      iaer_data  = vecs[v].aer;
      iaer_vld   = 1'b1;
      check($sformatf("v%0d_rdy", v), 72'(iaer_rdy), 72'd1);
      tick();
      iaer_vld  = 1'b0;
      iaer_data = '0;
      check($sformatf("v%0d_vld", v), 72'(ipkt_vld), 72'd1);
`ifdef IN_MAPPER_TSTAMP_EN
      check($sformatf("v%0d_key", v), 72'(ipkt_data[39:8]), 72'(vecs[v].key));
      check($sformatf("v%0d_hdr", v), 72'(ipkt_data[7:1]), 72'd1);
`else
      check($sformatf("v%0d_data", v), ipkt_data, {32'h0, vecs[v].key, vecs[v].hdr});
`endif
      check($sformatf("v%0d_parity", v), 72'(^ipkt_data), 72'd1);
      ipkt_rdy = 1'b1;
      tick();
      ipkt_rdy = 1'b0;
      exp_count = exp_count + 32'd1;
      check($sformatf("v%0d_empty", v), 72'(ipkt_vld), 72'd0);
      check($sformatf("v%0d_count", v), 72'(evt_count), 72'(exp_count));
    end

    // Back-pressure: 4 accepted, 5th held off, then drained in order
    do_reset();
    tick();
    key_mask   = 32'hFFFF_FFFF;
    key_prefix = '0;
    for (int i = 0; i < 5; i++) begin
      iaer_data = 32'h10 + 32'(i);
      iaer_vld  = 1'b1;
      check($sformatf("bp_rdy%0d", i), 72'(iaer_rdy), (i < 4) ? 72'd1 : 72'd0);
      if (i < 4) tick();
    end
    tick();
    check("bp_full_hold", 72'(iaer_rdy), 72'd0);
    ipkt_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      logic accepted;
      check($sformatf("bp_vld%0d", i), 72'(ipkt_vld), 72'd1);
      check($sformatf("bp_key%0d", i), 72'(ipkt_data[39:8]), 72'(32'h10 + 32'(i)));
      accepted = iaer_vld & iaer_rdy;
      tick();
      if (accepted) iaer_vld = 1'b0;
    end
    ipkt_rdy = 1'b0;
    check("bp_in_vld_dropped", 72'(iaer_vld), 72'd0);
    check("bp_drained", 72'(ipkt_vld), 72'd0);
    check("bp_count", 72'(evt_count), 72'd5);
    exp_count = 32'd5;

    // Streaming: one packet per clock, no bubbles
    ipkt_rdy = 1'b1;
    for (int c = 0; c <= 8; c++) begin
      if (c >= 1) begin
        check($sformatf("st_vld%0d", c), 72'(ipkt_vld), 72'd1);
        check($sformatf("st_key%0d", c), 72'(ipkt_data[39:8]), 72'(32'h20 + 32'(c - 1)));
      end
      iaer_vld  = (c < 8);
      iaer_data = 32'h20 + 32'(c);
      if (c < 8) check($sformatf("st_rdy%0d", c), 72'(iaer_rdy), 72'd1);
      tick();
    end
    iaer_vld = 1'b0;
    ipkt_rdy = 1'b0;
    exp_count = exp_count + 32'd8;
    check("st_empty", 72'(ipkt_vld), 72'd0);
    check("st_count", 72'(evt_count), 72'(exp_count));

    // Reset with two entries buffered
    for (int i = 0; i < 2; i++) begin
      iaer_data = 32'h30 + 32'(i);
      iaer_vld  = 1'b1;
      tick();
    end
    iaer_vld = 1'b0;
    check("mr_pre_vld", 72'(ipkt_vld), 72'd1);
    rst = 1'b1;
    #1;
    check("mr_vld", 72'(ipkt_vld), 72'd0);
    check("mr_count", 72'(evt_count), 72'd0);
    check("mr_data", ipkt_data, 72'd0);
    check("mr_rdy", 72'(iaer_rdy), 72'd0);
    tick();
    rst = 1'b0;
    ipkt_rdy = 1'b1;
    tick();
    check("mr_rdy_after", 72'(iaer_rdy), 72'd1);
    check("mr_no_stale", 72'(ipkt_vld), 72'd0);
    tick();
    check("mr_no_stale2", 72'(ipkt_vld), 72'd0);
    ipkt_rdy  = 1'b0;
    iaer_data = 32'h40;
    iaer_vld  = 1'b1;
    tick();
    iaer_vld = 1'b0;
    check("mr_new_key", 72'(ipkt_data[39:8]), 72'h40);
    check("mr_count_post", 72'(evt_count), 72'd0);

`ifdef IN_MAPPER_TSTAMP_EN
    // Timestamp: counter reads n-1 before the n-th edge after release
    rst = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    iaer_data = 32'h55;
    iaer_vld  = 1'b1;
    tick();
    iaer_vld = 1'b0;
    check("ts_payload", 72'(ipkt_data[71:40]), 72'h5);
    check("ts_flag", 72'(ipkt_data[1]), 72'd1);
    check("ts_parity", 72'(^ipkt_data), 72'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
